imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time loader sitting directly upstream of the single-cycle CPU's 4 KB instruction memory.
- Accepts a byte stream (from a UART/host link) over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the CPU out of execution (cpu_run low) until the whole program image is loaded.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; depth = 2**ADDR_W words (1024 = 4 KB).
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  single-cycle request to load a new image; honoured only in DONE.
- im_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- im_addr  output  ADDR_W  word address of the write.
- im_wdata  output  32  assembled instruction word.
- cpu_run  output  1  1 = image complete; CPU may fetch and execute.
- words_loaded  output  ADDR_W+1  count of words written in the current load.
- err  output  1  sticky: header count exceeded memory depth.

Behaviour:
- Frame format: 2-byte header (word count N, big-endian, high byte first), then N*4 data bytes. Each word is sent MSB first, so byte 0 goes to bits 31:24.
- Transfer rule: a byte transfers on a rising edge where in_valid && in_ready. in_data is ignored otherwise. in_valid may toggle freely.
- States: HDR_HI, HDR_LO, DATA, DONE, ERR.
- Reset (reset==0 at edge):
  - state <= HDR_HI.
  - im_we, im_addr, im_wdata, cpu_run, words_loaded, err, byte counter and word counter all <= 0.
  - in_ready is forced 0 while reset is low.
  - Instruction-memory contents are not cleared.
- in_ready = 1 in HDR_HI, HDR_LO and DATA (when words remain); 0 in DONE and ERR. It is combinational from state.
- HDR_HI: on transfer, latch N[15:8]; go to HDR_LO.
- HDR_LO: on transfer, latch N[7:0], then:
  - N == 0: go to DONE; cpu_run rises at the next edge.
  - N > 2**ADDR_W: go to ERR; err <= 1.
  - otherwise: go to DATA.
- DATA:
  - A 2-bit byte index shifts each byte into a 32-bit assembly register.
  - When the 4th byte of a word transfers at edge k:
    - im_we is 1 during cycle k..k+1 (registered, exactly one cycle).
    - im_addr = word index and im_wdata = the assembled word.
    - words_loaded increments at edge k.
  - Bytes of the next word may transfer during the im_we cycle (no bubble). Full throughput is 1 byte/cycle.
- Completion:
  - After the final (N-th) word's 4th byte, in_ready drops immediately.
  - State goes to DONE at the same edge.
  - cpu_run rises at edge k+2, one cycle after the last im_we pulse, so the memory holds the final word before the first fetch.
- DONE:
  - cpu_run = 1 and im_we = 0.
  - reload=1 at an edge: go to HDR_HI; cpu_run <= 0, words_loaded <= 0, byte and word counters <= 0.
- ERR: in_ready = 0, cpu_run = 0, err = 1. Only reset exits.
- reload is ignored in every state except DONE. A simultaneous reset wins over everything.
- Reset mid-load: the partial word is discarded, and words already written stay in memory. After reset the loader waits for a fresh header.
- Word address never wraps: N ≤ 2**ADDR_W is guaranteed by the ERR check, and N = 1024 writes addresses 0..1023.

Test Plan:
- Basic load:
  - Stimulus: after reset release, stream 00 02 | 20 08 00 05 | 01 09 50 20 at 1 byte/cycle.
  - Required: im_we pulses at addr 0 with 0x20080005, then at addr 1 with 0x01095020; words_loaded = 2; cpu_run rises exactly 2 cycles after the last byte transfers; in_ready = 0 afterwards.
- Backpressure and gaps:
  - Stimulus: same image with in_valid randomly deasserted for 0–5 cycles.
  - Required: identical writes and data; no byte lost or duplicated.
- Zero length:
  - Stimulus: header 00 00.
  - Required: no im_we pulse; cpu_run = 1 one cycle after HDR_LO; words_loaded = 0.
- Overflow:
  - Stimulus: header 04 01 (N = 1025).
  - Required: err = 1, in_ready = 0, no im_we pulse, cpu_run stays 0. A reset pulse then clears err and in_ready returns to 1.
- Reset mid-word:
  - Stimulus: header 00 01, then bytes AA BB, then reset low for 1 cycle, then a full frame 00 01 11 22 33 44.
  - Required: the single write is addr 0 = 0x11223344, with no write of a partial AABB word.
- Reload and full depth:
  - Stimulus: in DONE, pulse reload; send N = 1024 with data = word index.
  - Required: cpu_run drops the cycle after reload; 1024 writes at addr 0..1023 with no wrap; words_loaded = 1024; cpu_run rises again.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write / CPU-control signals of the boot loader.
// The master drives the stream; the slave (the loader) drives the memory port and status.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_run;
    logic [ADDR_W:0]   words_loaded;
    logic              err;

    modport master (
        output in_data, in_valid, reload,
        input  in_ready, im_we, im_addr, im_wdata, cpu_run, words_loaded, err
    );

    modport slave (
        input  in_data, in_valid, reload,
        output in_ready, im_we, im_addr, im_wdata, cpu_run, words_loaded, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses a word-count header, assembles big-endian words from a byte
// stream, writes them to instruction memory and releases the CPU once the image is complete.
module imem_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned WL_W  = ADDR_W + 1;

    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERR} state_e;

    state_e            state_q, state_d;
    logic [7:0]        hdr_hi_q, hdr_hi_d;
    logic [WL_W-1:0]   n_q, n_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_run_q, cpu_run_d;
    logic [WL_W-1:0]   words_loaded_q, words_loaded_d;
    logic              err_q, err_d;

    logic              ready_c;
    logic              xfer_c;
    logic [CNT_W-1:0]  hdr_n_c;
    logic [31:0]       word_c;
    logic              last_word_c;

    // Ready depends only on state; a pending reset blocks the stream.
    assign ready_c     = reset && (state_q == HDR_HI || state_q == HDR_LO || state_q == DATA);
    assign xfer_c      = bus.in_valid && ready_c;
    assign hdr_n_c     = CNT_W'({hdr_hi_q, bus.in_data});
    assign word_c      = {asm_q, bus.in_data};
    assign last_word_c = (words_loaded_q + WL_W'(1)) == n_q;

    always_comb begin
        state_d        = state_q;
        hdr_hi_d       = hdr_hi_q;
        n_d            = n_q;
        byte_idx_d     = byte_idx_q;
        asm_d          = asm_q;
        im_we_d        = 1'b0;
        im_addr_d      = im_addr_q;
        im_wdata_d     = im_wdata_q;
        cpu_run_d      = cpu_run_q;
        words_loaded_d = words_loaded_q;
        err_d          = err_q;

        case (state_q)
            HDR_HI: begin
                if (xfer_c) begin
                    hdr_hi_d = bus.in_data;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer_c) begin
                    if (hdr_n_c == '0) begin
                        state_d = DONE;
                    end else if (hdr_n_c > CNT_W'(DEPTH)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        n_d     = WL_W'(hdr_n_c);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer_c) begin
                    byte_idx_d = 2'(byte_idx_q + 2'd1);
                    asm_d      = {asm_q[15:0], bus.in_data};
                    if (byte_idx_q == 2'd3) begin
                        im_we_d        = 1'b1;
                        im_addr_d      = words_loaded_q[ADDR_W-1:0];
                        im_wdata_d     = word_c;
                        words_loaded_d = words_loaded_q + WL_W'(1);
                        if (last_word_c) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                // Hold the CPU one more cycle while the final write lands in memory.
                cpu_run_d = !im_we_q;
                if (bus.reload) begin
                    state_d        = HDR_HI;
                    cpu_run_d      = 1'b0;
                    words_loaded_d = '0;
                    byte_idx_d     = '0;
                end
            end
            ERR: begin
                cpu_run_d = 1'b0;
                err_d     = 1'b1;
            end
            default: begin
                state_d = HDR_HI;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= HDR_HI;
            hdr_hi_q       <= '0;
            n_q            <= '0;
            byte_idx_q     <= '0;
            asm_q          <= '0;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= '0;
            cpu_run_q      <= 1'b0;
            words_loaded_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            hdr_hi_q       <= hdr_hi_d;
            n_q            <= n_d;
            byte_idx_q     <= byte_idx_d;
            asm_q          <= asm_d;
            im_we_q        <= im_we_d;
            im_addr_q      <= im_addr_d;
            im_wdata_q     <= im_wdata_d;
            cpu_run_q      <= cpu_run_d;
            words_loaded_q <= words_loaded_d;
            err_q          <= err_d;
        end
    end

    assign bus.in_ready     = ready_c;
    assign bus.im_we        = im_we_q;
    assign bus.im_addr      = im_addr_q;
    assign bus.im_wdata     = im_wdata_q;
    assign bus.cpu_run      = cpu_run_q;
    assign bus.words_loaded = words_loaded_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every im_we pulse.
module tb_imem_loader;
    localparam int unsigned ADDR_W = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk;
    logic reset;
    int unsigned n_chk;
    int unsigned n_pass;
    int unsigned exp_addr;
    wr_t exp_q[$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {1'b1, 21'd0, bus.im_addr, bus.im_wdata}, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.im_addr), 64'(e.addr));
                chk("wr_data", 64'(bus.im_wdata), 64'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit done;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            repeat (gap) begin @(posedge clk); #1; end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic send_hdr(input logic [15:0] n, input int unsigned maxgap);
        send_byte(n[15:8], $urandom_range(0, maxgap));
        send_byte(n[7:0], $urandom_range(0, maxgap));
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned maxgap);
        wr_t e;
        e.addr = exp_addr[ADDR_W-1:0];
        e.data = w;
        exp_q.push_back(e);
        exp_addr++;
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.reload   = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_im_we", 64'(bus.im_we), 64'd0);
        chk("rst_cpu_run", 64'(bus.cpu_run), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_words", 64'(bus.words_loaded), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        exp_addr = 0;
    endtask

    // Called at #1 after the edge of the last byte: run must rise exactly two edges later.
    task automatic check_completion(input string tag, input logic [ADDR_W:0] words);
        bus.in_valid = 1'b0;
        chk({tag, "_ready_drop"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_run_k"}, 64'(bus.cpu_run), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_run_k1"}, 64'(bus.cpu_run), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_run_k2"}, 64'(bus.cpu_run), 64'd1);
        chk({tag, "_words"}, 64'(bus.words_loaded), 64'(words));
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        @(posedge clk); #1;
        bus.reload = 1'b0;
        chk("reload_run_drop", 64'(bus.cpu_run), 64'd0);
        chk("reload_words", 64'(bus.words_loaded), 64'd0);
        chk("reload_ready", 64'(bus.in_ready), 64'd1);
        exp_addr = 0;
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        exp_addr     = 0;
        reset        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.reload   = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Basic load at full rate
        send_hdr(16'd2, 0);
        send_word(32'h2008_0005, 0);
        send_word(32'h0109_5020, 0);
        check_completion("basic", 11'd2);

        // Same image with random gaps
        do_reload();
        send_hdr(16'd2, 5);
        send_word(32'h2008_0005, 5);
        send_word(32'h0109_5020, 5);
        check_completion("gaps", 11'd2);

        // Full depth, data = word index
        do_reload();
        send_hdr(16'd1024, 0);
        for (int i = 0; i < 1024; i++) send_word(32'(i), 0);
        check_completion("full", 11'd1024);

        // Zero length
        do_reset();
        send_hdr(16'd0, 0);
        bus.in_valid = 1'b0;
        chk("zero_run_early", 64'(bus.cpu_run), 64'd0);
        chk("zero_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("zero_run", 64'(bus.cpu_run), 64'd1);
        chk("zero_words", 64'(bus.words_loaded), 64'd0);

        // Overflow, reload ignored in ERR
        do_reset();
        send_hdr(16'd1025, 0);
        bus.in_valid = 1'b0;
        chk("ovf_err", 64'(bus.err), 64'd1);
        chk("ovf_ready", 64'(bus.in_ready), 64'd0);
        bus.reload = 1'b1;
        @(posedge clk); #1;
        bus.reload = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("ovf_err_hold", 64'(bus.err), 64'd1);
        chk("ovf_ready_hold", 64'(bus.in_ready), 64'd0);
        chk("ovf_run", 64'(bus.cpu_run), 64'd0);
        do_reset();

        // Reset mid-word discards the partial word
        send_hdr(16'd1, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_addr = 0;
        send_hdr(16'd1, 0);
        send_word(32'h1122_3344, 0);
        check_completion("midrst", 11'd1);

        repeat (3) begin @(posedge clk); #1; end
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
